// File: rtl/eth_vrl_deframer.sv
// eth_vrl_deframer
//   Strips the fixed Ethernet/IP/UDP header lines from frames arriving from
//   eth_dispatch, validates the VRL header line and forwards the VRT payload
//   to the radio core with zero latency. Keeps drop, sequence-error and
//   size-error counters for software.
//
// Ports
//   clk, reset, clear        clock, sync active-high reset, sync clear (same effect)
//   i_tdata/i_tuser/i_tlast  input line, byte occupancy (0 = 8 bytes, 4 = 4 bytes), last line
//   i_tvalid/i_tready        input handshake
//   o_tdata/o_tuser/o_tlast  forwarded line (combinational copy of the input)
//   o_tvalid/o_tready        output handshake
//   drop_count               frames discarded (runt or bad magic)
//   seq_err_count            VRL frame-counter discontinuities
//   size_err_count           VRL size field mismatches
//
// Handshake: a line moves when valid and ready are both high at a rising
// clock edge; valid never depends on ready. In pass-through states
// i_tready = o_tready and o_tvalid = i_tvalid, so a line is consumed exactly
// when it is delivered downstream. In discard states i_tready = 1 and
// o_tvalid = 0.
module eth_vrl_deframer #(
    parameter int HDR_LINES     = 6,
    parameter bit STRIP_VRL     = 1'b1,
    parameter int TRAILER_WORDS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [63:0] i_tdata,
    input  logic [3:0]  i_tuser,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic [3:0]  o_tuser,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] drop_count,
    output logic [31:0] seq_err_count,
    output logic [31:0] size_err_count
);

    typedef enum logic [1:0] {S_HDR, S_VRL, S_PAYLOAD, S_DROP} state_t;

    localparam int              LCW      = (HDR_LINES > 1) ? $clog2(HDR_LINES) : 1;
    localparam logic [LCW-1:0]  LAST_HDR = LCW'(HDR_LINES - 1);
    localparam logic [31:0]     MAGIC    = 32'h5652_4C50;
    localparam logic [19:0]     TRAILER  = 20'(TRAILER_WORDS);

    state_t           state_q, state_d;
    logic [LCW-1:0]   line_cnt_q, line_cnt_d;
    logic [19:0]      word_cnt_q, word_cnt_d;
    logic [19:0]      size_q, size_d;
    logic [11:0]      last_fc_q, last_fc_d;
    logic             seq_valid_q, seq_valid_d;
    logic [31:0]      drop_q, drop_d;
    logic [31:0]      seq_err_q, seq_err_d;
    logic [31:0]      size_err_q, size_err_d;

    logic             o_tvalid_c;
    logic             xfer;
    logic             magic_ok;
    logic [11:0]      vrl_fc;
    logic [19:0]      vrl_size;
    logic [19:0]      word_inc;
    logic [19:0]      word_final;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign magic_ok   = (i_tdata[63:32] == MAGIC);
    assign vrl_fc     = i_tdata[31:20];
    assign vrl_size   = i_tdata[19:0];
    // A half-occupied closing line carries one 32-bit word; anything else counts as two.
    assign word_inc   = (i_tlast && i_tuser == 4'd4) ? 20'd1 : 20'd2;
    assign word_final = word_cnt_q + word_inc;
    assign xfer       = i_tvalid && i_tready;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= S_HDR;
            line_cnt_q  <= '0;
            word_cnt_q  <= '0;
            size_q      <= '0;
            last_fc_q   <= '0;
            seq_valid_q <= 1'b0;
            drop_q      <= '0;
            seq_err_q   <= '0;
            size_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            word_cnt_q  <= word_cnt_d;
            size_q      <= size_d;
            last_fc_q   <= last_fc_d;
            seq_valid_q <= seq_valid_d;
            drop_q      <= drop_d;
            seq_err_q   <= seq_err_d;
            size_err_q  <= size_err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        word_cnt_d  = word_cnt_q;
        size_d      = size_q;
        last_fc_d   = last_fc_q;
        seq_valid_d = seq_valid_q;
        drop_d      = drop_q;
        seq_err_d   = seq_err_q;
        size_err_d  = size_err_q;
        case (state_q)
            S_HDR: begin
                if (xfer) begin
                    if (i_tlast) begin
                        drop_d     = sat_inc(drop_q);
                        line_cnt_d = '0;
                    end else if (line_cnt_q == LAST_HDR) begin
                        line_cnt_d = '0;
                        state_d    = S_VRL;
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
            end
            S_VRL: begin
                if (xfer) begin
                    if (!magic_ok) begin
                        drop_d  = sat_inc(drop_q);
                        state_d = i_tlast ? S_HDR : S_DROP;
                    end else if (i_tlast && STRIP_VRL) begin
                        // Header only, no payload: a runt. last_fc is left alone.
                        drop_d  = sat_inc(drop_q);
                        state_d = S_HDR;
                    end else begin
                        size_d      = vrl_size;
                        word_cnt_d  = 20'd2;
                        if (seq_valid_q && (vrl_fc != last_fc_q + 12'd1))
                            seq_err_d = sat_inc(seq_err_q);
                        last_fc_d   = vrl_fc;
                        seq_valid_d = 1'b1;
                        if (i_tlast) begin
                            // Forwarded VRL line that is also the last line.
                            if (vrl_size != 20'd2 + TRAILER)
                                size_err_d = sat_inc(size_err_q);
                            state_d = S_HDR;
                        end else begin
                            state_d = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    word_cnt_d = word_final;
                    if (i_tlast) begin
                        if (size_q != word_final + TRAILER)
                            size_err_d = sat_inc(size_err_q);
                        line_cnt_d = '0;
                        state_d    = S_HDR;
                    end
                end
            end
            S_DROP: begin
                if (xfer && i_tlast)
                    state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        i_tready   = 1'b1;
        o_tvalid_c = 1'b0;
        case (state_q)
            S_VRL: begin
                if (!STRIP_VRL && magic_ok) begin
                    i_tready   = o_tready;
                    o_tvalid_c = i_tvalid;
                end
            end
            S_PAYLOAD: begin
                i_tready   = o_tready;
                o_tvalid_c = i_tvalid;
            end
            default: begin
                i_tready   = 1'b1;
                o_tvalid_c = 1'b0;
            end
        endcase
    end

    // A line presented while reset/clear is active is discarded, so it must
    // not appear downstream either.
    assign o_tvalid       = o_tvalid_c && !reset && !clear;
    assign o_tdata        = i_tdata;
    assign o_tuser        = i_tuser;
    assign o_tlast        = i_tlast;
    assign drop_count     = drop_q;
    assign seq_err_count  = seq_err_q;
    assign size_err_count = size_err_q;

endmodule

// File: tb/tb_eth_vrl_deframer.sv
module tb_eth_vrl_deframer;

  localparam logic [31:0] MAGIC = 32'h5652_4C50;
  localparam logic [31:0] BAD   = 32'h5652_4C51;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, clear;

  logic [63:0] i_tdata;
  logic [3:0]  i_tuser;
  logic        i_tlast, i_tvalid, i_tready, o_tready;
  logic [63:0] o_tdata;
  logic [3:0]  o_tuser;
  logic        o_tlast, o_tvalid;
  logic [31:0] drop_count, seq_err_count, size_err_count;

  logic        i_tready0, o_tlast0, o_tvalid0;
  logic [63:0] o_tdata0;
  logic [3:0]  o_tuser0;
  logic [31:0] drop0, seq0, size0;

  eth_vrl_deframer #(.HDR_LINES(6), .STRIP_VRL(1'b1), .TRAILER_WORDS(1)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready),
    .drop_count(drop_count), .seq_err_count(seq_err_count),
    .size_err_count(size_err_count)
  );

  eth_vrl_deframer #(.HDR_LINES(6), .STRIP_VRL(1'b0), .TRAILER_WORDS(1)) dut0 (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready0),
    .o_tdata(o_tdata0), .o_tuser(o_tuser0), .o_tlast(o_tlast0),
    .o_tvalid(o_tvalid0), .o_tready(o_tready),
    .drop_count(drop0), .seq_err_count(seq0),
    .size_err_count(size0)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
    bit          pay;
  } beat_t;

  typedef struct {
    int          n_hdr;
    bit          has_vrl;
    logic [31:0] magic;
    logic [11:0] fc;
    logic [19:0] size;
    int          npay;
    logic [3:0]  last_user;
    int          exp_out;
    logic [31:0] exp_drop;
    logic [31:0] exp_seq;
    logic [31:0] exp_size;
  } vec_t;

  beat_t       tx_q[$];
  logic [68:0] exp_q[$];
  logic [68:0] got_q[$];
  logic [68:0] got0_q[$];

  int compared = 0;
  int mismatched = 0;

  // ---------------- output monitors ----------------
  always @(negedge clk) begin
    if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tuser, o_tdata});
    if (o_tvalid0 && o_tready) got0_q.push_back({o_tlast0, o_tuser0, o_tdata0});
  end

  // ---------------- checks ----------------
  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [68:0] got, input logic [68:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    check32({name, "_lines"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_line({name, "_data"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string name, input logic [31:0] d,
                                input logic [31:0] s, input logic [31:0] z);
    check32({name, "_drop"}, drop_count, d);
    check32({name, "_seq"}, seq_err_count, s);
    check32({name, "_size"}, size_err_count, z);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] pay_data(input int k, input int i);
    if (i == 0) return {32'h1010_0006, 24'h0, 8'(k)};
    return {8'hD0, 8'(k), 48'(i)};
  endfunction

  function automatic vec_t mk(input int n_hdr, input bit has_vrl, input logic [31:0] magic,
                              input logic [11:0] fc, input logic [19:0] size, input int npay,
                              input logic [3:0] lu, input int exp_out, input logic [31:0] d,
                              input logic [31:0] s, input logic [31:0] z);
    vec_t v;
    v.n_hdr = n_hdr; v.has_vrl = has_vrl; v.magic = magic; v.fc = fc; v.size = size;
    v.npay = npay; v.last_user = lu; v.exp_out = exp_out;
    v.exp_drop = d; v.exp_seq = s; v.exp_size = z;
    return v;
  endfunction

  // Queue the beats of one frame; the first exp_lines payload lines are expected downstream.
  task automatic build(input vec_t v, input int k, input int exp_lines);
    beat_t b;
    for (int i = 0; i < v.n_hdr; i++) begin
      b.data = {32'h4844_5200, 24'(k), 8'(i)};
      b.user = 4'd0;
      b.last = !v.has_vrl && (i == v.n_hdr - 1);
      b.pay  = 1'b0;
      tx_q.push_back(b);
    end
    if (v.has_vrl) begin
      b.data = {v.magic, v.fc, v.size};
      b.user = 4'd0;
      b.last = (v.npay == 0);
      b.pay  = 1'b0;
      tx_q.push_back(b);
    end
    for (int i = 0; i < v.npay; i++) begin
      b.data = pay_data(k, i);
      b.user = (i == v.npay - 1) ? v.last_user : 4'd0;
      b.last = (i == v.npay - 1);
      b.pay  = 1'b1;
      tx_q.push_back(b);
      if (i < exp_lines) exp_q.push_back({b.last, b.user, b.data});
    end
  endtask

  // Drive up to n queued beats. With toggle set, o_tready flips every cycle on payload beats.
  task automatic drive(input int n, input bit toggle);
    int sent = 0;
    int budget = 0;
    beat_t b;
    bit acc;
    while (sent < n && tx_q.size() > 0) begin
      b = tx_q[0];
      i_tvalid = 1'b1; i_tdata = b.data; i_tuser = b.user; i_tlast = b.last;
      if (toggle && b.pay) o_tready = ~o_tready;
      else o_tready = 1'b1;
      @(negedge clk);
      acc = i_tready;
      if (toggle && b.pay) check32("i_tready_mirror", 32'(i_tready), 32'(o_tready));
      @(posedge clk); #1;
      if (acc) begin
        void'(tx_q.pop_front());
        sent++;
      end
      budget++;
      if (budget > 2000) begin
        compared++;
        mismatched++;
        $display("FAIL drive_timeout: got %0d beats accepted expected %0d", sent, n);
        tx_q.delete();
        break;
      end
    end
    i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t vecs[16];
  vec_t v;
  beat_t bb;

  initial begin
    vecs[0]  = mk(6, 1, MAGIC, 12'd0,    20'd11, 4, 4'd0, 4, 0, 0, 0);
    vecs[1]  = mk(6, 1, MAGIC, 12'd1,    20'd11, 4, 4'd0, 4, 0, 0, 0);
    vecs[2]  = mk(6, 1, MAGIC, 12'd3,    20'd11, 4, 4'd0, 4, 0, 1, 0);
    vecs[3]  = mk(6, 1, MAGIC, 12'd4,    20'd11, 4, 4'd0, 4, 0, 1, 0);
    vecs[4]  = mk(6, 1, BAD,   12'd100,  20'd11, 3, 4'd0, 0, 1, 1, 0);
    vecs[5]  = mk(6, 1, MAGIC, 12'd5,    20'd11, 4, 4'd0, 4, 1, 1, 0);
    vecs[6]  = mk(4, 0, MAGIC, 12'd0,    20'd0,  0, 4'd0, 0, 2, 1, 0);
    vecs[7]  = mk(6, 1, MAGIC, 12'd6,    20'd11, 4, 4'd0, 4, 2, 1, 0);
    vecs[8]  = mk(6, 1, MAGIC, 12'd7,    20'd10, 4, 4'd4, 4, 2, 1, 0);
    vecs[9]  = mk(6, 1, MAGIC, 12'd8,    20'd12, 4, 4'd4, 4, 2, 1, 1);
    vecs[10] = mk(6, 1, MAGIC, 12'd9,    20'd9,  4, 4'd0, 4, 2, 1, 2);
    vecs[11] = mk(6, 1, MAGIC, 12'd4095, 20'd11, 4, 4'd0, 4, 2, 2, 2);
    vecs[12] = mk(6, 1, MAGIC, 12'd0,    20'd11, 4, 4'd0, 4, 2, 2, 2);
    vecs[13] = mk(6, 1, MAGIC, 12'd1,    20'd11, 4, 4'd2, 4, 2, 2, 2);
    vecs[14] = mk(6, 1, MAGIC, 12'd2,    20'd3,  0, 4'd0, 0, 3, 2, 2);
    vecs[15] = mk(6, 1, MAGIC, 12'd2,    20'd11, 4, 4'd0, 4, 3, 2, 2);

    reset = 1'b1; clear = 1'b0; o_tready = 1'b1;
    i_tvalid = 1'b1; i_tdata = {MAGIC, 32'h0}; i_tuser = 4'd0; i_tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_o_tvalid", 32'(o_tvalid), 32'd0);
    check32("reset_i_tready", 32'(i_tready), 32'd1);
    check_counters("reset", 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0; i_tvalid = 1'b0;
    got_q.delete(); got0_q.delete();

    // Table of whole frames; counters are cumulative.
    for (int r = 0; r < 16; r++) begin
      build(vecs[r], r, vecs[r].exp_out);
      drive(1000, 1'b0);
      settle();
      compare_stream($sformatf("vec%0d", r));
      check_counters($sformatf("vec%0d", r), vecs[r].exp_drop, vecs[r].exp_seq, vecs[r].exp_size);
    end

    // Back-pressure toggling every cycle during the payload.
    v = mk(6, 1, MAGIC, 12'd3, 20'd11, 4, 4'd0, 4, 3, 2, 2);
    build(v, 20, 4);
    drive(1000, 1'b1);
    settle();
    compare_stream("toggle");
    check_counters("toggle", 3, 2, 2);

    // Non-stripping instance: the VRL line leads the forwarded stream.
    got0_q.delete();
    v = mk(6, 1, MAGIC, 12'd1, 20'd9, 4, 4'd0, 4, 0, 0, 0);
    build(v, 21, 4);
    drive(1000, 1'b0);
    settle();
    compare_stream("strip0_main");
    check32("strip0_lines", got0_q.size(), 32'd5);
    if (got0_q.size() == 5) begin
      check_line("strip0_vrl", got0_q[0], {1'b0, 4'h0, 64'h5652_4C50_0010_0009});
      check_line("strip0_pay0", got0_q[1], {1'b0, 4'h0, pay_data(21, 0)});
      check_line("strip0_last", got0_q[4], {1'b1, 4'h0, pay_data(21, 3)});
    end

    // Clear in the middle of a payload, with a line on the bus.
    v = mk(6, 1, MAGIC, 12'd5, 20'd11, 4, 4'd0, 4, 0, 0, 0);
    build(v, 22, 1);
    drive(8, 1'b0);
    bb = tx_q.pop_front();
    i_tvalid = 1'b1; i_tdata = bb.data; i_tuser = bb.user; i_tlast = bb.last;
    clear = 1'b1;
    @(negedge clk);
    check32("clear_o_tvalid", 32'(o_tvalid), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; i_tvalid = 1'b0;
    @(negedge clk);
    check_counters("after_clear", 0, 0, 0);
    drive(1000, 1'b0);
    settle();
    compare_stream("clear_tail");
    check_counters("clear_tail", 1, 0, 0);
    v = mk(6, 1, MAGIC, 12'd50, 20'd11, 4, 4'd0, 4, 0, 0, 0);
    build(v, 23, 4);
    drive(1000, 1'b0);
    settle();
    compare_stream("post_clear");
    check_counters("post_clear", 1, 0, 0);

    // Reset in the middle of a long payload; the tail must be dropped.
    v = mk(6, 1, MAGIC, 12'd51, 20'd23, 10, 4'd0, 0, 0, 0, 0);
    build(v, 24, 2);
    drive(9, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_counters("after_reset", 0, 0, 0);
    drive(1000, 1'b0);
    settle();
    compare_stream("reset_tail");
    check_counters("reset_tail", 1, 0, 0);
    v = mk(6, 1, MAGIC, 12'd7, 20'd11, 4, 4'd0, 4, 0, 0, 0);
    build(v, 25, 4);
    drive(1000, 1'b0);
    settle();
    compare_stream("post_reset");
    check_counters("post_reset", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
